// File: rtl/fuse_pkg.sv
// Shared types and default sizes for the fuse timer block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fuse_pkg;

   localparam int N_CH_DEF       = 8;
   localparam int DUR_W_DEF      = 16;
   localparam int FIFO_DEPTH_DEF = 8;

   // Channel index width; never narrower than one bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CH_W_DEF = ch_width(N_CH_DEF);

   typedef logic [CH_W_DEF-1:0] ch_t;
   typedef logic [31:0]         deadline_t;

endpackage

// File: rtl/fuse_evt_fifo.sv
// Synchronous show-ahead FIFO holding expired channel IDs.
// Latency: a pushed entry is visible on dout the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; dout reads 0 when empty.
module fuse_evt_fifo
   import fuse_pkg::*;
#(
   parameter int W     = 3,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = count_q;
   assign dout    = empty ? '0 : mem_q[rd_q];

   // Storage write; contents are don't-care while empty, so no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fuse_timer.sv
// Multi-channel ms countdown: stores absolute deadlines, scans one channel per cycle, queues expiries.
// Latency: expiry reaches evt_valid at most N_CH+1 cycles after time_ms hits the deadline.
// Backpressure: full event FIFO holds expired channels active for retry; arm_ready only drops in reset.
// Optional feature macro: FUSE_CANCEL_EN (cancel requests clear a channel; otherwise cancel is ignored).
module fuse_timer
   import fuse_pkg::*;
#(
   parameter int N_CH       = N_CH_DEF,
   parameter int DUR_W      = DUR_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int CH_W      = ch_width(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       time_ms,
   input  logic              arm_valid,
   output logic              arm_ready,
   input  logic [CH_W-1:0]   arm_ch,
   input  logic [DUR_W-1:0]  arm_dur_ms,
   input  logic              cancel_valid,
   input  logic [CH_W-1:0]   cancel_ch,
   output logic [N_CH-1:0]   active,
   output logic              evt_valid,
   output logic [CH_W-1:0]   evt_ch,
   input  logic              evt_ready
);

   localparam logic [CH_W:0]   N_CH_L  = (CH_W+1)'(N_CH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH-1);

   deadline_t             deadline_q [N_CH];
   logic [N_CH-1:0]       active_q;
   logic [N_CH-1:0]       active_d;
   logic [CH_W-1:0]       ptr_q;
   logic [CH_W-1:0]       ptr_d;
   logic                  arm_ready_q;

   logic                  arm_hit;
   logic                  cancel_hit;
   deadline_t             diff;
   logic                  expired;
   logic                  push;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [$clog2(FIFO_DEPTH):0] evt_cnt_unused;

   // Out-of-range channel numbers are accepted but have no effect.
   assign arm_hit = arm_valid & arm_ready_q & ({1'b0, arm_ch} < N_CH_L);

`ifdef FUSE_CANCEL_EN
   assign cancel_hit = cancel_valid & ({1'b0, cancel_ch} < N_CH_L);
`else
   logic unused_cancel;
   assign unused_cancel = ^{cancel_valid, cancel_ch};
   assign cancel_hit    = 1'b0;
`endif

   // Wrap-safe compare: the deadline has passed once the difference is non-negative as signed.
   assign diff    = time_ms - deadline_q[ptr_q];
   assign expired = active_q[ptr_q] & ~diff[31]
                  & ~(arm_hit    && (arm_ch    == ptr_q))
                  & ~(cancel_hit && (cancel_ch == ptr_q));
   // Gated on the registered count so a full FIFO never accepts, even alongside a pop.
   assign push    = expired & ~fifo_full;

   // Next-state for armed flags and scan pointer; arm is applied last so it wins over cancel/expiry.
   always_comb begin
      active_d = active_q;
      if (push) begin
         active_d[ptr_q] = 1'b0;
      end
      if (cancel_hit) begin
         active_d[cancel_ch] = 1'b0;
      end
      if (arm_hit) begin
         active_d[arm_ch] = 1'b1;
      end
      ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + 1'b1;
   end

   // Channel state registers; arm stores an absolute deadline so the scan only needs a compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q    <= '0;
         ptr_q       <= '0;
         arm_ready_q <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            deadline_q[i] <= '0;
         end
      end else begin
         active_q    <= active_d;
         ptr_q       <= ptr_d;
         arm_ready_q <= 1'b1;
         if (arm_hit) begin
            deadline_q[arm_ch] <= time_ms + 32'(arm_dur_ms);
         end
      end
   end

   fuse_evt_fifo #(
      .W     (CH_W),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (ptr_q),
      .pop   (evt_ready),
      .dout  (evt_ch),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (evt_cnt_unused)
   );

   assign arm_ready = arm_ready_q;
   assign active    = active_q;
   assign evt_valid = ~fifo_empty;

endmodule

// File: tb/tb_fuse_timer.sv
// Directed bench for fuse_timer: table of single-cycle vectors plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_fuse_timer;
   import fuse_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] time_ms;
   logic        arm_valid;
   logic        arm_ready;
   logic [2:0]  arm_ch;
   logic [15:0] arm_dur_ms;
   logic        cancel_valid;
   logic [2:0]  cancel_ch;
   logic [7:0]  active;
   logic        evt_valid;
   logic [2:0]  evt_ch;
   logic        evt_ready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fuse_timer #(
      .N_CH       (8),
      .DUR_W      (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .time_ms      (time_ms),
      .arm_valid    (arm_valid),
      .arm_ready    (arm_ready),
      .arm_ch       (arm_ch),
      .arm_dur_ms   (arm_dur_ms),
      .cancel_valid (cancel_valid),
      .cancel_ch    (cancel_ch),
      .active       (active),
      .evt_valid    (evt_valid),
      .evt_ch       (evt_ch),
      .evt_ready    (evt_ready)
   );

   typedef struct {
      logic        rst;
      logic [31:0] t;
      logic        av;
      logic [2:0]  ach;
      logic [15:0] adur;
      logic        er;
      logic [7:0]  exp_active;
      logic        exp_ev;
      logic [2:0]  exp_ech;
      logic        exp_ard;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      arm_valid    = 1'b0;
      cancel_valid = 1'b0;
      evt_ready    = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic arm(input logic [31:0] t, input logic [2:0] ch, input logic [15:0] dur);
      time_ms    = t;
      arm_valid  = 1'b1;
      arm_ch     = ch;
      arm_dur_ms = dur;
      step();
      arm_valid  = 1'b0;
   endtask

   // Hold time_ms for a number of cycles with the FIFO drained, counting events seen.
   task automatic hold(input logic [31:0] t, input int cyc, output int n_evt, output logic [2:0] last);
      time_ms   = t;
      evt_ready = 1'b1;
      n_evt     = 0;
      last      = '0;
      for (int i = 0; i < cyc; i++) begin
         step();
         if (evt_valid) begin
            n_evt++;
            last = evt_ch;
         end
      end
   endtask

   initial begin
      int         n;
      int         tot;
      int         dup;
      logic [2:0] last;
      logic [7:0] mask;

      rst = 1'b0; time_ms = '0; arm_valid = 1'b0; arm_ch = '0; arm_dur_ms = '0;
      cancel_valid = 1'b0; cancel_ch = '0; evt_ready = 1'b0;

      // rst, t, av, ch, dur, er | active, evt_valid, evt_ch, arm_ready (after the edge)
      vecs[0]  = '{1'b1, 32'd0,   1'b0, 3'd0, 16'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
      vecs[1]  = '{1'b0, 32'd100, 1'b0, 3'd0, 16'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1};
      vecs[2]  = '{1'b0, 32'd100, 1'b1, 3'd3, 16'd5, 1'b0, 8'h08, 1'b0, 3'd0, 1'b1};
      vecs[3]  = '{1'b0, 32'd100, 1'b0, 3'd0, 16'd0, 1'b0, 8'h08, 1'b0, 3'd0, 1'b1};
      vecs[4]  = '{1'b0, 32'd100, 1'b0, 3'd0, 16'd0, 1'b0, 8'h08, 1'b0, 3'd0, 1'b1};
      for (int i = 5; i <= 11; i++) begin
         vecs[i] = '{1'b0, 32'd105, 1'b0, 3'd0, 16'd0, 1'b0, 8'h08, 1'b0, 3'd0, 1'b1};
      end
      vecs[12] = '{1'b0, 32'd105, 1'b0, 3'd0, 16'd0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1};
      vecs[13] = '{1'b0, 32'd105, 1'b0, 3'd0, 16'd0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b1};

      // Basic arm/expire: ch3 dur 5 at t=100, scan reaches ch3 eight cycles into t=105
      for (int i = 0; i < 14; i++) begin
         rst        = vecs[i].rst;
         time_ms    = vecs[i].t;
         arm_valid  = vecs[i].av;
         arm_ch     = vecs[i].ach;
         arm_dur_ms = vecs[i].adur;
         evt_ready  = vecs[i].er;
         step();
         chk($sformatf("v%0d_active", i),    32'(active),    32'(vecs[i].exp_active));
         chk($sformatf("v%0d_evt_valid", i), 32'(evt_valid), 32'(vecs[i].exp_ev));
         chk($sformatf("v%0d_evt_ch", i),    32'(evt_ch),    32'(vecs[i].exp_ech));
         chk($sformatf("v%0d_arm_ready", i), 32'(arm_ready), 32'(vecs[i].exp_ard));
      end
      arm_valid = 1'b0;
      evt_ready = 1'b0;

      // Timestamp wrap: deadline lands at 2 after wrapping
      do_reset();
      time_ms = 32'hFFFF_FFFE;
      step();
      arm(32'hFFFF_FFFE, 3'd0, 16'd4);
      hold(32'hFFFF_FFFF, 10, n, last); chk("wrap_none_ffffffff", 32'(n), 0);
      hold(32'd0, 10, n, last);         chk("wrap_none_0", 32'(n), 0);
      hold(32'd1, 10, n, last);         chk("wrap_none_1", 32'(n), 0);
      hold(32'd2, 10, n, last);         chk("wrap_evt_cnt_2", 32'(n), 1);
      chk("wrap_evt_ch", 32'(last), 0);
      chk("wrap_active_clr", 32'(active), 0);

      // FIFO full: eight zero-length fuses into a four-entry FIFO, then drain all
      do_reset();
      for (int c = 0; c < 8; c++) begin
         arm(32'd50, 3'(c), 16'd0);
      end
      for (int i = 0; i < 20; i++) step();
      chk("full_active_cnt", 32'($countones(active)), 4);
      chk("full_evt_valid", 32'(evt_valid), 1);
      evt_ready = 1'b1;
      tot = 0; dup = 0; mask = '0;
      for (int i = 0; i < 40; i++) begin
         if (evt_valid) begin
            tot++;
            if (mask[evt_ch]) dup++;
            mask[evt_ch] = 1'b1;
         end
         step();
      end
      chk("full_drain_total", 32'(tot), 8);
      chk("full_drain_mask", 32'(mask), 32'h0000_00FF);
      chk("full_drain_dup", 32'(dup), 0);
      chk("full_drain_active", 32'(active), 0);
      chk("full_drain_empty", 32'(evt_valid), 0);

      // Re-arm restarts: deadline moves from 10 to 15
      do_reset();
      arm(32'd0, 3'd1, 16'd10);
      tot = 0;
      for (int t = 1; t <= 4; t++) begin
         hold(32'(t), 10, n, last);
         tot += n;
      end
      arm(32'd5, 3'd1, 16'd10);
      for (int t = 5; t <= 14; t++) begin
         hold(32'(t), 10, n, last);
         tot += n;
      end
      chk("rearm_none_before_15", 32'(tot), 0);
      hold(32'd15, 10, n, last);
      chk("rearm_evt_cnt_15", 32'(n), 1);
      chk("rearm_evt_ch", 32'(last), 1);
      hold(32'd16, 20, n, last);
      chk("rearm_no_second", 32'(n), 0);

      // Cancel: ch2 dur 3 cancelled at t=1
      do_reset();
      arm(32'd0, 3'd2, 16'd3);
      time_ms      = 32'd1;
      cancel_valid = 1'b1;
      cancel_ch    = 3'd2;
      step();
      cancel_valid = 1'b0;
`ifdef FUSE_CANCEL_EN
      chk("cancel_active", 32'(active[2]), 0);
`else
      chk("cancel_active", 32'(active[2]), 1);
`endif
      tot = 0;
      hold(32'd1, 10, n, last); tot += n;
      hold(32'd2, 10, n, last); tot += n;
      chk("cancel_none_early", 32'(tot), 0);
      hold(32'd3, 10, n, last);
`ifdef FUSE_CANCEL_EN
      chk("cancel_evt_cnt_3", 32'(n), 0);
`else
      chk("cancel_evt_cnt_3", 32'(n), 1);
`endif
      hold(32'd4, 10, n, last);
      chk("cancel_none_after", 32'(n), 0);

      // Reset mid-operation: two queued events and three live channels are discarded
      do_reset();
      arm(32'd10, 3'd0, 16'd0);
      arm(32'd10, 3'd1, 16'd0);
      arm(32'd10, 3'd4, 16'd20);
      arm(32'd10, 3'd5, 16'd20);
      arm(32'd10, 3'd6, 16'd20);
      for (int i = 0; i < 10; i++) step();
      chk("mid_active", 32'(active), 32'h70);
      chk("mid_evt_valid", 32'(evt_valid), 1);
      rst = 1'b1;
      step();
      chk("mid_rst_active", 32'(active), 0);
      chk("mid_rst_evt_valid", 32'(evt_valid), 0);
      chk("mid_rst_evt_ch", 32'(evt_ch), 0);
      chk("mid_rst_arm_ready", 32'(arm_ready), 0);
      rst = 1'b0;
      tot = 0;
      hold(32'd10, 10, n, last); tot += n;
      hold(32'd30, 10, n, last); tot += n;
      hold(32'd31, 10, n, last); tot += n;
      chk("mid_no_old_events", 32'(tot), 0);
      chk("mid_arm_ready_back", 32'(arm_ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
